tank_hit_judge: RTL and testbench

Per-frame hit arbiter and scorekeeper for the two-player tank game. It compares each player's bullet against the opposing tank, drives the hold-length intersect levels the tank controllers consume to trigger a respawn, and keeps both scores. It also runs the PLAY/OVER game state. It sits between the two tank controllers and the VGA/HUD logic and is clocked once per video frame.

---
 rtl/tank_hit_judge.sv | 245 ++++++++++++++++++++++++
 tb/tb_tank_hit_judge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tank_hit_judge.sv
// Per-frame hit arbiter, intersect hold generator and scorekeeper
// for the two-player tank game, with PLAY/OVER game state.

module tank_hit_target #(
  parameter int HOLD_FRAMES     = 9,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ov,
  input  logic play,
  output logic hit_o,
  output logic intersect_o
);

  typedef enum logic [1:0] {
    T_IDLE,
    T_HIT,
    T_RECOVER
  } tstate_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);

  tstate_e    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       inter_q, inter_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inter_d = inter_q;
    hit_o   = 1'b0;
    unique case (state_q)
      T_IDLE: begin
        if (ov && play) begin
          state_d = T_HIT;
          inter_d = 1'b1;
          cnt_d   = 8'd0;
          hit_o   = 1'b1;
        end
      end
      T_HIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = T_RECOVER;
          inter_d = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      T_RECOVER: begin
        // the exit edge already acts as IDLE so a re-hit is not delayed
        if (cnt_q == COOL_LAST) begin
          state_d = T_IDLE;
          cnt_d   = 8'd0;
          if (ov && play) begin
            state_d = T_HIT;
            inter_d = 1'b1;
            hit_o   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = T_IDLE;
        inter_d = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
    if (clr) begin
      state_d = T_IDLE;
      inter_d = 1'b0;
      cnt_d   = 8'd0;
      hit_o   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T_IDLE;
      cnt_q   <= 8'd0;
      inter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inter_q <= inter_d;
    end
  end

  assign intersect_o = inter_q;

endmodule

module tank_hit_judge #(
  parameter int HOLD_FRAMES     = 9,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int WIN_SCORE       = 5
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       restart,
  input  logic [9:0] Bullet1X,
  input  logic [9:0] Bullet1Y,
  input  logic [9:0] Bullet1S,
  input  logic [9:0] Tank1X,
  input  logic [9:0] Tank1Y,
  input  logic [9:0] Tank1S,
  input  logic [9:0] Bullet2X,
  input  logic [9:0] Bullet2Y,
  input  logic [9:0] Bullet2S,
  input  logic [9:0] Tank2X,
  input  logic [9:0] Tank2Y,
  input  logic [9:0] Tank2S,
  output logic       Bullet1_Tank2_intersect,
  output logic       Bullet2_Tank1_intersect,
  output logic [3:0] Score1,
  output logic [3:0] Score2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic {
    G_PLAY,
    G_OVER
  } gstate_e;

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  function automatic logic overlap(
    input logic [9:0] bx,
    input logic [9:0] by,
    input logic [9:0] bs,
    input logic [9:0] tx,
    input logic [9:0] ty,
    input logic [9:0] ts
  );
    logic [10:0] dx, dy, ax, ay, lim;
    dx  = {1'b0, bx} - {1'b0, tx};
    dy  = {1'b0, by} - {1'b0, ty};
    ax  = dx[10] ? (~dx + 11'd1) : dx;
    ay  = dy[10] ? (~dy + 11'd1) : dy;
    lim = {1'b0, bs} + {1'b0, ts};
    return (ax <= lim) && (ay <= lim);
  endfunction

  logic    ov12, ov21;
  logic    hit12, hit21;
  logic    play, clr;
  gstate_e gstate_q, gstate_d;
  logic    [3:0] score1_q, score1_d;
  logic    [3:0] score2_q, score2_d;
  logic    go_q, go_d;
  logic    [1:0] win_q, win_d;
  logic    reach1, reach2;

  assign ov12 = overlap(Bullet1X, Bullet1Y, Bullet1S,
                        Tank2X, Tank2Y, Tank2S);
  assign ov21 = overlap(Bullet2X, Bullet2Y, Bullet2S,
                        Tank1X, Tank1Y, Tank1S);

  assign play = (gstate_q == G_PLAY);
  assign clr  = (gstate_q == G_OVER) && restart;

  tank_hit_target #(
    .HOLD_FRAMES    (HOLD_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_t12 (
    .clk        (frame_clk),
    .rst        (Reset),
    .clr        (clr),
    .ov         (ov12),
    .play       (play),
    .hit_o      (hit12),
    .intersect_o(Bullet1_Tank2_intersect)
  );

  tank_hit_target #(
    .HOLD_FRAMES    (HOLD_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
  ) u_t21 (
    .clk        (frame_clk),
    .rst        (Reset),
    .clr        (clr),
    .ov         (ov21),
    .play       (play),
    .hit_o      (hit21),
    .intersect_o(Bullet2_Tank1_intersect)
  );

  always_comb begin
    score1_d = score1_q;
    score2_d = score2_q;
    gstate_d = gstate_q;
    go_d     = go_q;
    win_d    = win_q;
    if (hit12 && (score1_q != 4'hf)) score1_d = score1_q + 4'd1;
    if (hit21 && (score2_q != 4'hf)) score2_d = score2_q + 4'd1;
    reach1 = (score1_d == WIN) && (score1_q != WIN);
    reach2 = (score2_d == WIN) && (score2_q != WIN);
    unique case (gstate_q)
      G_PLAY: begin
        if (reach1 || reach2) begin
          gstate_d = G_OVER;
          go_d     = 1'b1;
          win_d    = {reach2, reach1};
        end
      end
      G_OVER: begin
        if (restart) begin
          gstate_d = G_PLAY;
          go_d     = 1'b0;
          win_d    = 2'b00;
          score1_d = 4'd0;
          score2_d = 4'd0;
        end
      end
      default: gstate_d = G_PLAY;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      gstate_q <= G_PLAY;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      go_q     <= 1'b0;
      win_q    <= 2'b00;
    end else begin
      gstate_q <= gstate_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      go_q     <= go_d;
      win_q    <= win_d;
    end
  end

  assign Score1    = score1_q;
  assign Score2    = score2_q;
  assign game_over = go_q;
  assign winner    = win_q;

endmodule

// File: tb/tb_tank_hit_judge.sv
// Directed scoreboard bench for tank_hit_judge: stimulus queues the
// expected outputs per frame, a monitor pops and compares each frame.

module tb_tank_hit_judge;

  typedef struct packed {
    logic       i12;
    logic       i21;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       go;
    logic [1:0] win;
  } exp_t;

  logic       frame_clk = 1'b0;
  logic       Reset, restart;
  logic [9:0] Bullet1X, Bullet1Y, Bullet1S;
  logic [9:0] Tank1X, Tank1Y, Tank1S;
  logic [9:0] Bullet2X, Bullet2Y, Bullet2S;
  logic [9:0] Tank2X, Tank2Y, Tank2S;
  logic       Bullet1_Tank2_intersect;
  logic       Bullet2_Tank1_intersect;
  logic [3:0] Score1, Score2;
  logic       game_over;
  logic [1:0] winner;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   step_no = 0;

  tank_hit_judge dut (
    .frame_clk              (frame_clk),
    .Reset                  (Reset),
    .restart                (restart),
    .Bullet1X               (Bullet1X),
    .Bullet1Y               (Bullet1Y),
    .Bullet1S               (Bullet1S),
    .Tank1X                 (Tank1X),
    .Tank1Y                 (Tank1Y),
    .Tank1S                 (Tank1S),
    .Bullet2X               (Bullet2X),
    .Bullet2Y               (Bullet2Y),
    .Bullet2S               (Bullet2S),
    .Tank2X                 (Tank2X),
    .Tank2Y                 (Tank2Y),
    .Tank2S                 (Tank2S),
    .Bullet1_Tank2_intersect(Bullet1_Tank2_intersect),
    .Bullet2_Tank1_intersect(Bullet2_Tank1_intersect),
    .Score1                 (Score1),
    .Score2                 (Score2),
    .game_over              (game_over),
    .winner                 (winner)
  );

  always #5 frame_clk = ~frame_clk;

  // monitor: every frame edge presents a new output set
  initial begin
    exp_t e, a;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {Bullet1_Tank2_intersect, Bullet2_Tank1_intersect,
             Score1, Score2, game_over, winner};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL frame%0d got i12=%b i21=%b s1=%0d s2=%0d go=%b w=%b want i12=%b i21=%b s1=%0d s2=%0d go=%b w=%b",
                      step_no, a.i12, a.i21, a.s1, a.s2, a.go, a.win,
                      e.i12, e.i21, e.s1, e.s2, e.go, e.win);
      end
    end
  end

  task automatic step(input logic i12, input logic i21,
                      input int s1, input int s2,
                      input logic go, input logic [1:0] win);
    exp_t e;
    e.i12 = i12;
    e.i21 = i21;
    e.s1  = 4'(s1);
    e.s2  = 4'(s2);
    e.go  = go;
    e.win = win;
    exp_q.push_back(e);
    @(posedge frame_clk);
    @(negedge frame_clk);
    step_no++;
  endtask

  // tanks far apart; idle bullets on their own tank centres
  task automatic b1_idle();
    Bullet1X = 10'd800; Bullet1Y = 10'd400; Bullet1S = 10'd4;
  endtask
  task automatic b2_idle();
    Bullet2X = 10'd110; Bullet2Y = 10'd100; Bullet2S = 10'd4;
  endtask
  task automatic b1_shoot();
    Bullet1X = 10'd100; Bullet1Y = 10'd100;
  endtask
  task automatic b2_shoot();
    Bullet2X = 10'd800; Bullet2Y = 10'd405;
  endtask

  initial begin
    Reset = 1'b1;
    restart = 1'b0;
    Tank1X = 10'd800; Tank1Y = 10'd400; Tank1S = 10'd8;
    Tank2X = 10'd110; Tank2Y = 10'd100; Tank2S = 10'd18;
    b1_idle();
    b2_idle();

    // reset state
    step(0, 0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 0, 2'b00);
    Reset = 1'b0;
    step(0, 0, 0, 0, 0, 2'b00);

    // single shot: 9 edges high, then 4 cooldown edges low
    b1_shoot();
    for (int k = 0; k < 13; k++) begin
      step(k < 9, 0, 1, 0, 0, 2'b00);
      b1_idle();
    end

    // sustained overlap: one hit every 13 edges
    b1_shoot();
    for (int k = 0; k < 26; k++)
      step((k % 13) < 9, 0, (k < 13) ? 2 : 3, 0, 0, 2'b00);
    b1_idle();
    for (int k = 0; k < 4; k++) step(0, 0, 3, 0, 0, 2'b00);

    // boundaries: X diff 23, Y diff 23, 10-bit wrap -> no hit
    Bullet1X = 10'd87; Bullet1Y = 10'd100;
    step(0, 0, 3, 0, 0, 2'b00);
    Bullet1X = 10'd110; Bullet1Y = 10'd123;
    step(0, 0, 3, 0, 0, 2'b00);
    Tank2X = 10'd1020;
    Bullet2X = 10'd1020;
    Bullet1X = 10'd0; Bullet1Y = 10'd100;
    step(0, 0, 3, 0, 0, 2'b00);
    Tank2X = 10'd110;
    b2_idle();
    // X diff exactly 22 -> hit
    Bullet1X = 10'd88; Bullet1Y = 10'd100;
    for (int k = 0; k < 13; k++) begin
      step(k < 9, 0, 4, 0, 0, 2'b00);
      b1_idle();
    end
    step(0, 0, 4, 0, 0, 2'b00);

    // player 2 scores four hits with a sustained overlap
    b2_shoot();
    for (int k = 0; k < 52; k++)
      step(0, (k % 13) < 9, 4, k / 13 + 1, 0, 2'b00);
    b2_idle();
    step(0, 0, 4, 4, 0, 2'b00);

    // simultaneous deciding hits -> draw; OVER freezes new hits
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || k >= 13) begin
        b1_shoot();
        b2_shoot();
      end else begin
        b1_idle();
        b2_idle();
      end
      step(k < 9, k < 9, 5, 5, 1, 2'b11);
    end

    // restart clears; held restart in PLAY is ignored
    restart = 1'b1;
    step(0, 0, 0, 0, 0, 2'b00);
    step(1, 1, 1, 1, 0, 2'b00);
    restart = 1'b0;
    b1_idle();
    b2_idle();
    for (int k = 1; k < 4; k++) step(1, 1, 1, 1, 0, 2'b00);

    // reset mid-hold, overlap persists -> fresh hit next edge
    Reset = 1'b1;
    b1_shoot();
    step(0, 0, 0, 0, 0, 2'b00);
    Reset = 1'b0;
    step(1, 0, 1, 0, 0, 2'b00);
    b1_idle();
    step(1, 0, 1, 0, 0, 2'b00);
    step(1, 0, 1, 0, 0, 2'b00);

    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
